// File: rtl/sc_pkg.sv
// sc_pkg: shared lane/time widths, types and popcount helper for the match arbiter
package sc_pkg;
  localparam int SC_N_LANES = 37;
  localparam int SC_TIME_W = 16;
  localparam int SC_LANE_W = 6;
  typedef logic [SC_LANE_W-1:0] lane_t;
  typedef logic [SC_TIME_W-1:0] stime_t;
  function automatic lane_t popcnt(input logic [SC_N_LANES-1:0] v);
    lane_t c;
    c = '0;
    for (int i = 0; i < SC_N_LANES; i++) c = c + lane_t'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/sc_rr_picker.sv
// sc_rr_picker: first set request after ptr, scanning upward with wrap
module sc_rr_picker
  import sc_pkg::*;
(
  input  logic [SC_N_LANES-1:0] req,
  input  lane_t                 ptr,
  output logic                  any,
  output lane_t                 idx
);
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = SC_N_LANES; k >= 1; k--)
      if (req[(int'(ptr) + k) % SC_N_LANES]) idx = lane_t'((int'(ptr) + k) % SC_N_LANES);
  end
endmodule

// File: rtl/sc_match_arbiter.sv
// sc_match_arbiter: latches lane match times and grants pending lanes round-robin with dt
module sc_match_arbiter
  import sc_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset_n,
  input  stime_t                          song_time,
  input  logic [SC_N_LANES-1:0]           match_trigger,
  input  logic [SC_N_LANES*SC_TIME_W-1:0] match_time,
  output logic                            out_valid,
  input  logic                            out_ready,
  output lane_t                           out_lane,
  output stime_t                          out_dt,
  output logic [SC_N_LANES-1:0]           pending,
  output lane_t                           queue,
  output logic                            overflow,
  input  logic                            clear_overflow
);
  logic any, load;
  lane_t win, ptr;
  stime_t slot [SC_N_LANES];
  logic [SC_N_LANES-1:0] gnt, cap, pend_nxt;
  sc_rr_picker u_pick (.req(pending), .ptr(ptr), .any(any), .idx(win));
  always_comb begin
    load = (!out_valid | out_ready) & any;
    gnt = load ? {{(SC_N_LANES-1){1'b0}}, 1'b1} << win : '0;
    cap = match_trigger & (~pending | gnt);
    pend_nxt = (pending & ~gnt) | match_trigger;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pending <= '0;
      queue <= '0;
      out_valid <= 1'b0;
      out_lane <= '0;
      out_dt <= '0;
      overflow <= 1'b0;
      ptr <= lane_t'(SC_N_LANES - 1);
      for (int i = 0; i < SC_N_LANES; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < SC_N_LANES; i++)
        if (cap[i]) slot[i] <= match_time[i*SC_TIME_W +: SC_TIME_W];
      pending <= pend_nxt;
      queue <= popcnt(pend_nxt);
      overflow <= |(match_trigger & ~cap) | (overflow & ~clear_overflow);
      out_valid <= load | (out_valid & !out_ready);
      if (load) begin
        out_lane <= win;
        out_dt <= song_time - slot[win];
        ptr <= win;
      end
    end
endmodule
